// File: rtl/execute_pipe_stage.sv
// execute_pipe_stage: DE register (S1) -> ALU / result muxes -> EM register (S2)
// with valid/ready backpressure, flush and registered N/Z flags.
// Optional feature macro: EXEC_FWD_EN enables EM->EX operand forwarding.
module execute_pipe_stage #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_W  = 4,
  parameter int unsigned CTRL_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_aluop,
  input  logic              in_am,
  input  logic              in_alu_mux,
  input  logic              in_alu_mux1,
  input  logic              in_wbs,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [REG_W-1:0]  in_reg_dest,
  input  logic [REG_W-1:0]  in_srcA_id,
  input  logic [REG_W-1:0]  in_srcB_id,
  input  logic [DATA_W-1:0] in_srcA,
  input  logic [DATA_W-1:0] in_srcB,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [DATA_W-1:0] out_wdata,
  output logic              out_flagN,
  output logic              out_flagZ,
  output logic              out_wbs,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [REG_W-1:0]  out_reg_dest
);

  localparam int unsigned SH_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_AND   = 3'b010,
    ALU_OR    = 3'b011,
    ALU_XOR   = 3'b100,
    ALU_SHL   = 3'b101,
    ALU_SHR   = 3'b110,
    ALU_PASSB = 3'b111
  } alu_op_e;

  // S1 (DE) register
  logic              r_s1_valid;
  alu_op_e           r_s1_aluop;
  logic              r_s1_am;
  logic              r_s1_alu_mux;
  logic              r_s1_alu_mux1;
  logic              r_s1_wbs;
  logic [CTRL_W-1:0] r_s1_ctrl;
  logic [REG_W-1:0]  r_s1_reg_dest;
  logic [DATA_W-1:0] r_s1_srcA;
  logic [DATA_W-1:0] r_s1_srcB;

  // S2 (EM) register
  logic              r_s2_valid;
  logic [DATA_W-1:0] r_s2_result;
  logic [DATA_W-1:0] r_s2_wdata;
  logic              r_s2_wbs;
  logic [CTRL_W-1:0] r_s2_ctrl;
  logic [REG_W-1:0]  r_s2_reg_dest;
  logic              r_flagN;
  logic              r_flagZ;

  logic              w_adv1;
  logic              w_adv2;
  logic [DATA_W-1:0] w_opa;
  logic [DATA_W-1:0] w_opb;
  logic [DATA_W-1:0] w_alu;
  logic [DATA_W-1:0] w_rd_addr;
  logic [DATA_W-1:0] w_m0;
  logic [DATA_W-1:0] w_result;
  logic [DATA_W-1:0] w_wdata;

  assign w_adv2   = !r_s2_valid || out_ready;
  assign w_adv1   = !r_s1_valid || w_adv2;
  assign in_ready = rst_n && w_adv1;

`ifdef EXEC_FWD_EN
  logic [REG_W-1:0] r_s1_srcA_id;
  logic [REG_W-1:0] r_s1_srcB_id;
  logic             w_fwd_live;

  assign w_fwd_live = r_s2_valid && r_s2_wbs && (r_s2_reg_dest != '0);

  // Source ids travel with the op so the EM hazard check sees the S1 op's ids.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_srcA_id <= '0;
      r_s1_srcB_id <= '0;
    end else if (!flush && w_adv1) begin
      r_s1_srcA_id <= in_srcA_id;
      r_s1_srcB_id <= in_srcB_id;
    end
  end

  // Operand select: EM result overrides a stale latched operand (A and B independently).
  always_comb begin
    w_opa = r_s1_srcA;
    w_opb = r_s1_srcB;
    if (w_fwd_live && (r_s2_reg_dest == r_s1_srcA_id)) begin
      w_opa = r_s2_result;
    end
    if (w_fwd_live && (r_s2_reg_dest == r_s1_srcB_id)) begin
      w_opb = r_s2_result;
    end
  end
`else
  logic w_unused_src_ids;
  assign w_unused_src_ids = ^{in_srcA_id, in_srcB_id};

  // Operand select: latched operands used as-is.
  always_comb begin
    w_opa = r_s1_srcA;
    w_opb = r_s1_srcB;
  end
`endif

  // ALU, modulo 2^DATA_W.
  always_comb begin
    w_alu = '0;
    case (r_s1_aluop)
      ALU_ADD:   w_alu = w_opa + w_opb;
      ALU_SUB:   w_alu = w_opa - w_opb;
      ALU_AND:   w_alu = w_opa & w_opb;
      ALU_OR:    w_alu = w_opa | w_opb;
      ALU_XOR:   w_alu = w_opa ^ w_opb;
      ALU_SHL:   w_alu = w_opa << w_opb[SH_W-1:0];
      ALU_SHR:   w_alu = w_opa >> w_opb;
      ALU_PASSB: w_alu = w_opb;
      default:   w_alu = '0;
    endcase
  end

  // Result muxes: read-address path, ALU/address select, A passthrough, store data.
  always_comb begin
    w_rd_addr = r_s1_am ? '0 : w_opb;
    w_m0      = r_s1_alu_mux ? w_rd_addr : w_alu;
    w_result  = r_s1_alu_mux1 ? w_m0 : w_opa;
    w_wdata   = r_s1_am ? w_opb : '0;
  end

  // S1: loads on adv1; flush clears only the valid bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid    <= 1'b0;
      r_s1_aluop    <= ALU_ADD;
      r_s1_am       <= 1'b0;
      r_s1_alu_mux  <= 1'b0;
      r_s1_alu_mux1 <= 1'b0;
      r_s1_wbs      <= 1'b0;
      r_s1_ctrl     <= '0;
      r_s1_reg_dest <= '0;
      r_s1_srcA     <= '0;
      r_s1_srcB     <= '0;
    end else if (flush) begin
      r_s1_valid <= 1'b0;
    end else if (w_adv1) begin
      r_s1_valid    <= in_valid;
      r_s1_aluop    <= alu_op_e'(in_aluop);
      r_s1_am       <= in_am;
      r_s1_alu_mux  <= in_alu_mux;
      r_s1_alu_mux1 <= in_alu_mux1;
      r_s1_wbs      <= in_wbs;
      r_s1_ctrl     <= in_ctrl;
      r_s1_reg_dest <= in_reg_dest;
      r_s1_srcA     <= in_srcA;
      r_s1_srcB     <= in_srcB;
    end
  end

  // S2: loads the S1 result on adv2; flags move only with a valid op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid    <= 1'b0;
      r_s2_result   <= '0;
      r_s2_wdata    <= '0;
      r_s2_wbs      <= 1'b0;
      r_s2_ctrl     <= '0;
      r_s2_reg_dest <= '0;
      r_flagN       <= 1'b0;
      r_flagZ       <= 1'b0;
    end else if (flush) begin
      r_s2_valid <= 1'b0;
    end else if (w_adv2) begin
      r_s2_valid    <= r_s1_valid;
      r_s2_result   <= w_result;
      r_s2_wdata    <= w_wdata;
      r_s2_wbs      <= r_s1_wbs;
      r_s2_ctrl     <= r_s1_ctrl;
      r_s2_reg_dest <= r_s1_reg_dest;
      if (r_s1_valid) begin
        r_flagN <= w_result[DATA_W-1];
        r_flagZ <= (w_result == '0);
      end
    end
  end

  assign out_valid    = r_s2_valid;
  assign out_result   = r_s2_result;
  assign out_wdata    = r_s2_wdata;
  assign out_flagN    = r_flagN;
  assign out_flagZ    = r_flagZ;
  assign out_wbs      = r_s2_valid && r_s2_wbs;
  assign out_ctrl     = r_s2_valid ? r_s2_ctrl : '0;
  assign out_reg_dest = r_s2_reg_dest;

endmodule

// File: tb/tb_execute_pipe_stage.sv
`timescale 1ns/1ps
// Randomized and directed bench for execute_pipe_stage against a queue-based model.
module tb_execute_pipe_stage;

  localparam int unsigned DW = 16;
  localparam int unsigned RW = 4;
  localparam int unsigned CW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    in_aluop = '0;
  logic          in_am = 1'b0;
  logic          in_alu_mux = 1'b0;
  logic          in_alu_mux1 = 1'b0;
  logic          in_wbs = 1'b0;
  logic [CW-1:0] in_ctrl = '0;
  logic [RW-1:0] in_reg_dest = '0;
  logic [RW-1:0] in_srcA_id = '0;
  logic [RW-1:0] in_srcB_id = '0;
  logic [DW-1:0] in_srcA = '0;
  logic [DW-1:0] in_srcB = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_result;
  logic [DW-1:0] out_wdata;
  logic          out_flagN;
  logic          out_flagZ;
  logic          out_wbs;
  logic [CW-1:0] out_ctrl;
  logic [RW-1:0] out_reg_dest;

  always #5 clk = ~clk;

  execute_pipe_stage #(.DATA_W(DW), .REG_W(RW), .CTRL_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_aluop(in_aluop), .in_am(in_am), .in_alu_mux(in_alu_mux), .in_alu_mux1(in_alu_mux1),
    .in_wbs(in_wbs), .in_ctrl(in_ctrl), .in_reg_dest(in_reg_dest),
    .in_srcA_id(in_srcA_id), .in_srcB_id(in_srcB_id),
    .in_srcA(in_srcA), .in_srcB(in_srcB),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_wdata(out_wdata),
    .out_flagN(out_flagN), .out_flagZ(out_flagZ),
    .out_wbs(out_wbs), .out_ctrl(out_ctrl), .out_reg_dest(out_reg_dest)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Model: ops in flight, oldest first; age = clock edges since acceptance.
  typedef struct {
    logic [DW-1:0] res;
    logic [DW-1:0] wdata;
    logic          wbs;
    logic [CW-1:0] ctrl;
    logic [RW-1:0] dest;
    int unsigned   age;
  } op_t;

  op_t  q[$];
  logic last_n = 1'b0;
  logic last_z = 1'b0;

  function automatic logic [DW-1:0] ref_result(input logic [2:0] op, input logic am,
      input logic mux, input logic mux1, input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [31:0]   x;
    logic [31:0]   y;
    logic [31:0]   r;
    logic [DW-1:0] alu;
    logic [DW-1:0] m0;
    x = 32'(a);
    y = 32'(b);
    case (op)
      3'd0: r = x + y;
      3'd1: r = x - y;
      3'd2: r = x & y;
      3'd3: r = x | y;
      3'd4: r = x ^ y;
      3'd5: r = x << (y % 32'(DW));
      3'd6: r = (y >= 32'(DW)) ? 32'd0 : (x >> y);
      default: r = y;
    endcase
    alu = r[DW-1:0];
    m0  = mux ? (am ? '0 : b) : alu;
    return mux1 ? m0 : a;
  endfunction

  task automatic check_outputs();
    op_t  e;
    logic exp_valid;
    exp_valid = (q.size() > 0) && (q[0].age >= 2);
    check("out_valid", 32'(out_valid), 32'(exp_valid));
    if (exp_valid) begin
      e = q[0];
      last_n = e.res[DW-1];
      last_z = (e.res == '0);
      check("out_result", 32'(out_result), 32'(e.res));
      check("out_wdata", 32'(out_wdata), 32'(e.wdata));
      check("out_wbs", 32'(out_wbs), 32'(e.wbs));
      check("out_ctrl", 32'(out_ctrl), 32'(e.ctrl));
      check("out_reg_dest", 32'(out_reg_dest), 32'(e.dest));
    end else begin
      check("idle_wbs", 32'(out_wbs), 32'd0);
      check("idle_ctrl", 32'(out_ctrl), 32'd0);
    end
    check("flagN", 32'(out_flagN), 32'(last_n));
    check("flagZ", 32'(out_flagZ), 32'(last_z));
  endtask

  // One clock: drive, predict ready/accept/pop, advance model at the edge, check.
  task automatic cycle(input logic v, input logic [2:0] op, input logic am, input logic mux,
      input logic mux1, input logic wbs, input logic [CW-1:0] ctrl, input logic [RW-1:0] dest,
      input logic [DW-1:0] a, input logic [DW-1:0] b, input logic ordy, input logic fl);
    logic exp_ready;
    logic exp_valid;
    logic acc;
    logic pop;
    op_t  e;
    in_valid = v; in_aluop = op; in_am = am; in_alu_mux = mux; in_alu_mux1 = mux1;
    in_wbs = wbs; in_ctrl = ctrl; in_reg_dest = dest; in_srcA_id = '0; in_srcB_id = '0;
    in_srcA = a; in_srcB = b; out_ready = ordy; flush = fl;
    #1;
    exp_valid = (q.size() > 0) && (q[0].age >= 2);
    exp_ready = !((q.size() == 2) && !ordy);
    check("in_ready", 32'(in_ready), 32'(exp_ready));
    acc = v && exp_ready && !fl;
    pop = exp_valid && ordy && !fl;
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      if (pop) e = q.pop_front();
      for (int i = 0; i < q.size(); i++) begin
        e = q[i];
        e.age++;
        q[i] = e;
      end
      if (acc) begin
        e.res   = ref_result(op, am, mux, mux1, a, b);
        e.wdata = am ? b : '0;
        e.wbs   = wbs;
        e.ctrl  = ctrl;
        e.dest  = dest;
        e.age   = 1;
        q.push_back(e);
      end
    end
    #1;
    check_outputs();
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0, ordy, 1'b0);
  endtask

  task automatic op_simple(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
      input logic [RW-1:0] dest, input logic ordy);
    cycle(1'b1, op, 1'b0, 1'b0, 1'b1, 1'b1, 6'(dest), dest, a, b, ordy, 1'b0);
  endtask

  // Asynchronous reset asserted mid-cycle; everything in flight is discarded.
  task automatic do_reset();
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_result", 32'(out_result), 32'd0);
    check("rst_out_wdata", 32'(out_wdata), 32'd0);
    check("rst_flags", 32'({out_flagN, out_flagZ}), 32'd0);
    check("rst_wbs_ctrl_dest", 32'({out_wbs, out_ctrl, out_reg_dest}), 32'd0);
    q.delete();
    last_n = 1'b0;
    last_z = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [DW-1:0] ra;
    logic [DW-1:0] rb;
    int unsigned   mode;

    // Power-on reset
    do_reset();

    // Single add 1+1
    op_simple(3'd0, 16'd1, 16'd1, 4'd3, 1'b1);
    idle(1'b1);
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_result", 32'(out_result), 32'd2);
    check("t1_NZ", 32'({out_flagN, out_flagZ}), 32'd0);

    // Back-to-back sub 2-1, 1-1
    op_simple(3'd1, 16'd2, 16'd1, 4'd4, 1'b1);
    op_simple(3'd1, 16'd1, 16'd1, 4'd5, 1'b1);
    check("t2_res1", 32'(out_result), 32'd1);
    idle(1'b1);
    check("t2_res2", 32'(out_result), 32'd0);
    check("t2_Z", 32'(out_flagZ), 32'd1);
    idle(1'b1);

    // Store: am=1, alu_mux=1 -> address 0, write data B
    cycle(1'b1, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 6'h15, 4'd6, 16'd3, 16'h00AA, 1'b1, 1'b0);
    idle(1'b1);
    check("t3_result", 32'(out_result), 32'd0);
    check("t3_wdata", 32'(out_wdata), 32'h00AA);
    check("t3_Z", 32'(out_flagZ), 32'd1);
    idle(1'b1);

    // Backpressure: three ops against out_ready=0
    op_simple(3'd0, 16'd10, 16'd1, 4'd1, 1'b0);
    op_simple(3'd0, 16'd20, 16'd2, 4'd2, 1'b0);
    op_simple(3'd0, 16'd30, 16'd3, 4'd3, 1'b0);
    check("t4_stalled_ready", 32'(in_ready), 32'd0);
    op_simple(3'd0, 16'd30, 16'd3, 4'd3, 1'b1);
    for (int i = 0; i < 4; i++) idle(1'b1);

    // Flush with full pipe and a simultaneous accept
    op_simple(3'd4, 16'h8000, 16'h0001, 4'd7, 1'b0);
    op_simple(3'd0, 16'h0005, 16'h0005, 4'd8, 1'b0);
    cycle(1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 6'h3F, 4'd9, 16'd7, 16'd7, 1'b0, 1'b1);
    check("t5_valid", 32'(out_valid), 32'd0);
    check("t5_ready", 32'(in_ready), 32'd1);
    check("t5_flagN_held", 32'(out_flagN), 32'd1);
    idle(1'b1);
    idle(1'b1);

    // Random traffic with a mid-run reset
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset();
      ra   = DW'($urandom);
      mode = $urandom_range(0, 3);
      rb   = (mode == 0) ? ra : (mode == 1) ? DW'($urandom_range(0, 20)) : DW'($urandom);
      cycle($urandom_range(0, 3) != 0, 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), CW'($urandom), RW'($urandom), ra, rb,
            $urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0);
    end

    // Forwarding: r1 = 1+1, then r2 = r1 + 1 with stale A=0
    do_reset();
    in_valid = 1'b1; in_aluop = 3'd0; in_am = 1'b0; in_alu_mux = 1'b0; in_alu_mux1 = 1'b1;
    in_wbs = 1'b1; in_ctrl = '0; in_reg_dest = 4'd1; in_srcA_id = '0; in_srcB_id = '0;
    in_srcA = 16'd1; in_srcB = 16'd1; out_ready = 1'b1; flush = 1'b0;
    @(posedge clk); #1;
    in_reg_dest = 4'd2; in_srcA_id = 4'd1; in_srcA = 16'd0; in_srcB = 16'd1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_srcA_id = '0;
    check("t6_first", 32'(out_result), 32'd2);
    @(posedge clk); #1;
    check("t6_valid", 32'(out_valid), 32'd1);
    check("t6_dest", 32'(out_reg_dest), 32'd2);
`ifdef EXEC_FWD_EN
    check("t6_result", 32'(out_result), 32'd3);
`else
    check("t6_result", 32'(out_result), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
